// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: control sequencer for the byte-serial AES datapath.
// Buffers one plaintext/key block and walks the datapath through its rounds.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake for plain/key (128b each)
//   out_valid/out_ready   downstream handshake for zipher (128b)
//   dp_plain/dp_key       buffered block presented to the datapath
//   dp_load, dp_ark0      load and initial AddRoundKey strobes
//   dp_byte_en/_idx       byte step strobe and lane 0..15
//   dp_mix_en/dp_col      column mix strobe and column
//   dp_round, dp_final    current round (0 outside rounds), last-round flag
//   dp_state              datapath state, captured into zipher
//   busy                  engine not idle
// Optional: define AES_SEQ_PERF_EN to add perf_blocks/perf_stall counters.

module aes_round_sequencer #(
  parameter int NR      = 10,
  parameter int MIX_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plain,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] zipher,
  output logic [127:0] dp_plain,
  output logic [127:0] dp_key,
  output logic         dp_load,
  output logic         dp_ark0,
  output logic         dp_byte_en,
  output logic [3:0]   dp_byte_idx,
  output logic         dp_mix_en,
  output logic [1:0]   dp_col,
  output logic [3:0]   dp_round,
  output logic         dp_final,
  input  logic [127:0] dp_state,
  output logic         busy
`ifdef AES_SEQ_PERF_EN
  ,
  output logic [15:0]  perf_blocks,
  output logic [15:0]  perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARK0,
    S_BYTES,
    S_MIX,
    S_CAP
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(NR);
  localparam logic [3:0] LAST_COL = 4'(MIX_LAT - 1);

  state_t     state_q, state_d;
  logic       buf_full;
  logic [3:0] cnt_q;
  logic [3:0] round_q;
  logic       accept;
  logic       last_rnd;
  logic       cap;

  assign in_ready = !buf_full;
  assign accept   = in_valid && !buf_full;
  assign last_rnd = (round_q == LAST_RND);
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    dp_load     = 1'b0;
    dp_ark0     = 1'b0;
    dp_byte_en  = 1'b0;
    dp_mix_en   = 1'b0;
    dp_final    = 1'b0;
    dp_byte_idx = '0;
    dp_col      = '0;
    dp_round    = '0;
    cap         = 1'b0;
    unique case (state_q)
      // Starting on the accept itself puts LOAD
      // in the cycle right after acceptance.
      S_IDLE: begin
        if (buf_full || accept)
          state_d = S_LOAD;
      end
      S_LOAD: begin
        dp_load = 1'b1;
        state_d = S_ARK0;
      end
      S_ARK0: begin
        dp_ark0 = 1'b1;
        state_d = S_BYTES;
      end
      S_BYTES: begin
        dp_byte_en  = 1'b1;
        dp_byte_idx = cnt_q;
        dp_round    = round_q;
        dp_final    = last_rnd;
        if (cnt_q == 4'd15)
          state_d = last_rnd ? S_CAP : S_MIX;
      end
      S_MIX: begin
        dp_mix_en = 1'b1;
        dp_col    = cnt_q[1:0];
        dp_round  = round_q;
        if (cnt_q == LAST_COL)
          state_d = S_BYTES;
      end
      S_CAP: begin
        if (!out_valid || out_ready) begin
          cap     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      buf_full  <= 1'b0;
      dp_plain  <= '0;
      dp_key    <= '0;
      cnt_q     <= '0;
      round_q   <= '0;
      out_valid <= 1'b0;
      zipher    <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == S_LOAD)
        buf_full <= 1'b0;
      else if (accept)
        buf_full <= 1'b1;

      if (accept) begin
        dp_plain <= plain;
        dp_key   <= key;
      end

      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == S_BYTES || state_q == S_MIX)
        cnt_q <= cnt_q + 4'd1;

      if (state_q == S_LOAD)
        round_q <= 4'd1;
      else if (state_q == S_MIX && state_d == S_BYTES)
        round_q <= round_q + 4'd1;

      // A reload in the handshake cycle keeps
      // out_valid high with the new result.
      if (cap) begin
        out_valid <= 1'b1;
        zipher    <= dp_state;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef AES_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_blocks <= '0;
      perf_stall  <= '0;
    end else begin
      if (cap)
        perf_blocks <= perf_blocks + 16'd1;
      if (state_q == S_CAP && !cap && perf_stall != 16'hFFFF)
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: scoreboard bench for aes_round_sequencer.
// Directed timing cases followed by randomized traffic.

module tb_aes_round_sequencer;

  localparam int NR      = 10;
  localparam int MIX_LAT = 4;
  localparam int LAT     = 4 + 16 * NR + MIX_LAT * (NR - 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] plain = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] zipher;
  logic [127:0] dp_plain;
  logic [127:0] dp_key;
  logic         dp_load;
  logic         dp_ark0;
  logic         dp_byte_en;
  logic [3:0]   dp_byte_idx;
  logic         dp_mix_en;
  logic [1:0]   dp_col;
  logic [3:0]   dp_round;
  logic         dp_final;
  logic [127:0] dp_state = '0;
  logic         busy;
`ifdef AES_SEQ_PERF_EN
  logic [15:0]  perf_blocks;
  logic [15:0]  perf_stall;
`endif

  aes_round_sequencer #(.NR(NR), .MIX_LAT(MIX_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .plain(plain), .key(key),
    .out_valid(out_valid), .out_ready(out_ready),
    .zipher(zipher),
    .dp_plain(dp_plain), .dp_key(dp_key),
    .dp_load(dp_load), .dp_ark0(dp_ark0),
    .dp_byte_en(dp_byte_en), .dp_byte_idx(dp_byte_idx),
    .dp_mix_en(dp_mix_en), .dp_col(dp_col),
    .dp_round(dp_round), .dp_final(dp_final),
    .dp_state(dp_state), .busy(busy)
`ifdef AES_SEQ_PERF_EN
    , .perf_blocks(perf_blocks), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] idx;
    logic [1:0] col;
    logic [3:0] rnd;
    logic       fin;
  } ev_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [127:0] exp_q[$];
  logic [127:0] res_q[$];
  ev_t          ev_q[$];
  int           acc_t[$];
  int           load_t[$];
  int           ark_t[$];
  int           ov_t[$];
  int           stall_n = 0;
  int           blocks_n = 0;
  logic         st_arm = 1'b0;
  logic [127:0] st_val = '0;
  logic         prev_ov = 1'b0;
  logic         prev_rdy = 1'b0;
  logic [127:0] prev_z = '0;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in for the datapath result of one block.
  function automatic logic [127:0] cipher_of(input logic [127:0] p,
                                             input logic [127:0] k);
    return (p ^ {k[63:0], k[127:64]}) + 128'd1;
  endfunction

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int idx, input int col,
                         input int rnd, input bit fin);
    ev_t e;
    e.kind = 2'(kind);
    e.idx  = 4'(idx);
    e.col  = 2'(col);
    e.rnd  = 4'(rnd);
    e.fin  = fin;
    ev_q.push_back(e);
  endtask

  // Datapath stand-in: garbage except after the final byte step.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    dp_state <= st_arm ? st_val : rnd128();
  end

  always @(negedge clk) begin
    ev_t  a;
    ev_t  e;
    logic any;
    if (rst) begin
      exp_q.delete();
      res_q.delete();
      ev_q.delete();
      st_arm   = 1'b0;
      stall_n  = 0;
      blocks_n = 0;
      prev_ov  = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cipher_of(plain, key));
        res_q.push_back(cipher_of(plain, key));
        acc_t.push_back(cyc);
        push_ev(0, 0, 0, 0, 1'b0);
        push_ev(1, 0, 0, 0, 1'b0);
        for (int r = 1; r <= NR; r++) begin
          for (int i = 0; i < 16; i++)
            push_ev(2, i, 0, r, r == NR);
          if (r < NR)
            for (int c = 0; c < MIX_LAT; c++)
              push_ev(3, 0, c, r, 1'b0);
        end
      end

      any = dp_load | dp_ark0 | dp_byte_en | dp_mix_en;
      if (any) begin
        chki("strobe_onehot",
             $countones({dp_load, dp_ark0, dp_byte_en, dp_mix_en}), 1);
        a.kind = dp_ark0 ? 2'd1 : dp_byte_en ? 2'd2 :
                 dp_mix_en ? 2'd3 : 2'd0;
        a.idx  = dp_byte_idx;
        a.col  = dp_col;
        a.rnd  = dp_round;
        a.fin  = dp_final;
        if (ev_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL dp_event_extra: got %0h want none", a);
        end else begin
          e = ev_q.pop_front();
          chki("dp_event", int'(a), int'(e));
          if (e.kind == 2'd2 && e.fin && e.idx == 4'd15 &&
              res_q.size() > 0) begin
            st_val = res_q.pop_front();
            st_arm = 1'b1;
          end
        end
        if (dp_load) begin
          load_t.push_back(cyc);
          st_arm = 1'b0;
        end
        if (dp_ark0) ark_t.push_back(cyc);
      end else begin
        chki("idle_outs",
             int'({dp_round, dp_byte_idx, dp_col, dp_final}), 0);
      end

      if (busy && !any && out_valid && !out_ready) stall_n++;

      if (prev_ov && !prev_rdy) begin
        chki("hold_valid", int'(out_valid), 1);
        chk("hold_zipher", zipher, prev_z);
      end

      if (out_valid && (!prev_ov || prev_rdy)) begin
        ov_t.push_back(cyc);
        blocks_n++;
      end

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL zipher_extra: got %0h want none", zipher);
        end else begin
          chk("zipher", zipher, exp_q.pop_front());
        end
      end

      prev_ov  = out_valid;
      prev_rdy = out_ready;
      prev_z   = zipher;
    end
  end

  task automatic send(output int t);
    plain    = rnd128();
    key      = rnd128();
    in_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        t = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    plain    = rnd128();
    key      = rnd128();
    if (t < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no in_ready want in_ready");
    end
  endtask

  task automatic wait_ov(input int n);
    for (int i = 0; i < 3000; i++) begin
      if (ov_t.size() >= n) break;
      @(posedge clk);
    end
    #1;
    if (ov_t.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ov_timeout: got %0d results want %0d",
               ov_t.size(), n);
    end
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int  t0;
    int  t1;
    int  b;
    int  s0;
    bit  rnd_on;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chki("rst_in_ready", int'(in_ready), 1);
    chki("rst_out_valid", int'(out_valid), 0);
    chki("rst_busy", int'(busy), 0);
    chk("rst_zipher", zipher, '0);
    chk("rst_dp_plain", dp_plain, '0);
    chk("rst_dp_key", dp_key, '0);
    chki("rst_strobes",
         int'({dp_load, dp_ark0, dp_byte_en, dp_mix_en}), 0);

    // Single block, no output stall.
    @(posedge clk);
    #1;
    b = ov_t.size();
    s0 = load_t.size();
    send(t0);
    wait_ov(b + 1);
    chki("single_load", qat(load_t, s0), t0 + 1);
    chki("single_ark0", qat(ark_t, s0), t0 + 2);
    chki("single_ov", qat(ov_t, b), t0 + LAT);
    repeat (3) @(posedge clk);
    chki("single_ev_drained", ev_q.size(), 0);
`ifdef AES_SEQ_PERF_EN
    chki("perf_blocks_1", int'(perf_blocks), 1);
`endif

    // Back-to-back: second block offered 5 cycles after the first.
    repeat (5) @(posedge clk);
    #1;
    b = ov_t.size();
    s0 = load_t.size();
    send(t0);
    @(negedge clk);
    chki("b2b_in_ready_lo", int'(in_ready), 0);
    @(negedge clk);
    chki("b2b_in_ready_hi", int'(in_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    send(t1);
    chki("b2b_accept", t1, t0 + 5);
    wait_ov(b + 2);
    chki("b2b_load2", qat(load_t, s0 + 1), t0 + LAT + 1);
    chki("b2b_ov2", qat(ov_t, b + 1), t0 + 2 * LAT);

    // Output stall with a second result waiting in CAPTURE.
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b0;
    b = ov_t.size();
    send(t0);
    send(t1);
    wait_ov(b + 1);
    s0 = stall_n;
    for (int i = 0; i < 2000; i++) begin
      if (stall_n - s0 >= 20) break;
      @(posedge clk);
    end
    #1;
    chki("stall_cycles", stall_n - s0, 20);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chki("stall_no_gap", int'(out_valid), 1);
    @(posedge clk);
    #1;
`ifdef AES_SEQ_PERF_EN
    chki("perf_stall_20", int'(perf_stall), 20);
`endif

    // Reset mid-round with a result still pending.
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    b = ov_t.size();
    send(t0);
    wait_ov(b + 1);
    send(t0);
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chki("rrst_busy", int'(busy), 0);
    chki("rrst_in_ready", int'(in_ready), 1);
    chki("rrst_out_valid", int'(out_valid), 0);
    chki("rrst_strobes",
         int'({dp_load, dp_ark0, dp_byte_en, dp_mix_en}), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    b = ov_t.size();
    send(t0);
    wait_ov(b + 1);
    chki("rrst_ov", qat(ov_t, b), t0 + LAT);
`ifdef AES_SEQ_PERF_EN
    chki("perf_blocks_rst", int'(perf_blocks), 1);
`endif

    // Randomized traffic with random backpressure.
    rnd_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 12; n++) begin
          repeat ($urandom_range(0, 250)) @(posedge clk);
          #1;
          send(t0);
        end
        for (int i = 0; i < 4000; i++) begin
          if (exp_q.size() == 0 && !busy) break;
          @(posedge clk);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chki("rand_drained", exp_q.size(), 0);
    chki("rand_ev_drained", ev_q.size(), 0);
    chki("rand_idle", int'(busy), 0);
`ifdef AES_SEQ_PERF_EN
    chki("perf_blocks_end", int'(perf_blocks), blocks_n);
    chki("perf_stall_end", int'(perf_stall), stall_n);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
